// File: rtl/coreriscv_axi4_arb_pkg.sv
// Shared constants and message layout for the AXI4 beat-lock arbiter.
// A message beat is packed MSB-first as {src, dst, addr_block, p_type, has_data},
// so has_data always sits in bit 0 regardless of the address width.
package coreriscv_axi4_arb_pkg;

    localparam int NIN         = 4;
    localparam int IDX_W       = 2;
    localparam int HDR_W       = 2;
    localparam int P_TYPE_W    = 2;
    localparam int HAS_DATA_W  = 1;
    localparam int ADDR_W_DFLT = 26;

    // Message bundle at the default address width; the arbiter carries the
    // same field order in flat vectors so ADDR_W can be overridden.
    typedef struct packed {
        logic [HDR_W-1:0]       header_src;
        logic [HDR_W-1:0]       header_dst;
        logic [ADDR_W_DFLT-1:0] payload_addr_block;
        logic [P_TYPE_W-1:0]    payload_p_type;
        logic                   payload_has_data;
    } arb_msg_t;

    // Total width of one flattened message beat for a given address width.
    function automatic int msg_width(input int addr_w);
        return 2 * HDR_W + addr_w + P_TYPE_W + HAS_DATA_W;
    endfunction

    // Requester index k steps after base, wrapping modulo NIN.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int k);
        return base + IDX_W'(k);
    endfunction

endpackage

// File: rtl/coreriscv_axi4_arb_out_slice.sv
// Two-entry output skid buffer for the beat-lock arbiter. The output is
// driven straight from storage registers, so the arbiter's combinational
// select path ends here. Two entries let a new beat enter every cycle
// while the downstream handshake is in flight, giving full throughput.
// Only instantiated when CORERISCV_AXI4_ARB_OUT_REG_EN is defined.
module coreriscv_axi4_arb_out_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Occupancy and pointer bookkeeping; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/coreriscv_axi4_beat_lock_arbiter.sv
// Four-input round-robin arbiter that locks onto a requester for the whole
// of a multi-beat (has_data) message so beats of different messages never
// interleave. Optional macro CORERISCV_AXI4_ARB_OUT_REG_EN inserts a
// registered 2-entry output slice; without it the output is a pure
// combinational mux of the chosen input.
module coreriscv_axi4_beat_lock_arbiter
    import coreriscv_axi4_arb_pkg::*;
#(
    parameter int NBEATS = 4,
    parameter int ADDR_W = 26
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              io_in_0_valid,
    output logic              io_in_0_ready,
    input  logic [1:0]        io_in_0_bits_header_src,
    input  logic [1:0]        io_in_0_bits_header_dst,
    input  logic [ADDR_W-1:0] io_in_0_bits_payload_addr_block,
    input  logic [1:0]        io_in_0_bits_payload_p_type,
    input  logic              io_in_0_bits_payload_has_data,

    input  logic              io_in_1_valid,
    output logic              io_in_1_ready,
    input  logic [1:0]        io_in_1_bits_header_src,
    input  logic [1:0]        io_in_1_bits_header_dst,
    input  logic [ADDR_W-1:0] io_in_1_bits_payload_addr_block,
    input  logic [1:0]        io_in_1_bits_payload_p_type,
    input  logic              io_in_1_bits_payload_has_data,

    input  logic              io_in_2_valid,
    output logic              io_in_2_ready,
    input  logic [1:0]        io_in_2_bits_header_src,
    input  logic [1:0]        io_in_2_bits_header_dst,
    input  logic [ADDR_W-1:0] io_in_2_bits_payload_addr_block,
    input  logic [1:0]        io_in_2_bits_payload_p_type,
    input  logic              io_in_2_bits_payload_has_data,

    input  logic              io_in_3_valid,
    output logic              io_in_3_ready,
    input  logic [1:0]        io_in_3_bits_header_src,
    input  logic [1:0]        io_in_3_bits_header_dst,
    input  logic [ADDR_W-1:0] io_in_3_bits_payload_addr_block,
    input  logic [1:0]        io_in_3_bits_payload_p_type,
    input  logic              io_in_3_bits_payload_has_data,

    input  logic              io_out_ready,
    output logic              io_out_valid,
    output logic [1:0]        io_out_bits_header_src,
    output logic [1:0]        io_out_bits_header_dst,
    output logic [ADDR_W-1:0] io_out_bits_payload_addr_block,
    output logic [1:0]        io_out_bits_payload_p_type,
    output logic              io_out_bits_payload_has_data,
    output logic [1:0]        io_chosen
);

    localparam int MSG_W  = msg_width(ADDR_W);
    localparam int BCNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(NBEATS - 1);

    logic [NIN-1:0]   in_valid;
    logic [NIN-1:0]   in_ready;
    logic [MSG_W-1:0] msg_vec [NIN];

    logic [IDX_W-1:0] last_grant;
    logic             locked;
    logic [IDX_W-1:0] lock_idx;
    logic [BCNT_W-1:0] beat_cnt;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [MSG_W-1:0] sel_msg;
    logic             accept_ok;
    logic             hs;
    logic [MSG_W-1:0] out_msg;

    assign in_valid = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};

    assign msg_vec[0] = {io_in_0_bits_header_src, io_in_0_bits_header_dst,
                         io_in_0_bits_payload_addr_block, io_in_0_bits_payload_p_type,
                         io_in_0_bits_payload_has_data};
    assign msg_vec[1] = {io_in_1_bits_header_src, io_in_1_bits_header_dst,
                         io_in_1_bits_payload_addr_block, io_in_1_bits_payload_p_type,
                         io_in_1_bits_payload_has_data};
    assign msg_vec[2] = {io_in_2_bits_header_src, io_in_2_bits_header_dst,
                         io_in_2_bits_payload_addr_block, io_in_2_bits_payload_p_type,
                         io_in_2_bits_payload_has_data};
    assign msg_vec[3] = {io_in_3_bits_header_src, io_in_3_bits_header_dst,
                         io_in_3_bits_payload_addr_block, io_in_3_bits_payload_p_type,
                         io_in_3_bits_payload_has_data};

    // Pick the requester: the lock owner while mid-message, otherwise the
    // first valid one after lastGrant in rotating order, ending at lastGrant.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_index(last_grant, 1);
        if (locked) begin
            sel_idx   = lock_idx;
            sel_found = in_valid[lock_idx];
        end else begin
            for (int k = 1; k <= NIN; k++) begin
                if (!sel_found && in_valid[rr_index(last_grant, k)]) begin
                    sel_found = 1'b1;
                    sel_idx   = rr_index(last_grant, k);
                end
            end
        end
    end

    assign sel_msg = msg_vec[sel_idx];
    assign hs      = sel_found & accept_ok;

    // Only the chosen requester ever sees ready, and only when the next
    // stage can take a beat.
    always_comb begin
        in_ready          = '0;
        in_ready[sel_idx] = accept_ok;
    end

    assign io_in_0_ready = in_ready[0];
    assign io_in_1_ready = in_ready[1];
    assign io_in_2_ready = in_ready[2];
    assign io_in_3_ready = in_ready[3];

    // Round-robin pointer and message lock, advanced on each accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= '0;
            locked     <= 1'b0;
            lock_idx   <= '0;
            beat_cnt   <= '0;
        end else if (hs) begin
            last_grant <= sel_idx;
            if (locked) begin
                if (beat_cnt == LAST_BEAT) begin
                    locked   <= 1'b0;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end else if (sel_msg[0] && (NBEATS > 1)) begin
                locked   <= 1'b1;
                lock_idx <= sel_idx;
                beat_cnt <= BCNT_W'(1);
            end
        end
    end

`ifdef CORERISCV_AXI4_ARB_OUT_REG_EN
    logic                   slice_in_ready;
    logic [IDX_W+MSG_W-1:0] slice_out_data;

    assign accept_ok = slice_in_ready;

    coreriscv_axi4_arb_out_slice #(
        .W (IDX_W + MSG_W)
    ) u_out_slice (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (sel_found),
        .in_ready  (slice_in_ready),
        .in_data   ({sel_idx, sel_msg}),
        .out_valid (io_out_valid),
        .out_ready (io_out_ready),
        .out_data  (slice_out_data)
    );

    assign {io_chosen, out_msg} = slice_out_data;
`else
    assign accept_ok    = io_out_ready;
    assign io_out_valid = sel_found;
    assign io_chosen    = sel_idx;
    assign out_msg      = sel_msg;
`endif

    assign {io_out_bits_header_src, io_out_bits_header_dst,
            io_out_bits_payload_addr_block, io_out_bits_payload_p_type,
            io_out_bits_payload_has_data} = out_msg;

endmodule

// File: tb/tb_coreriscv_axi4_beat_lock_arbiter.sv
// Scoreboard bench for the beat-lock arbiter in its default (combinational
// output) build. The stimulus side tracks arbitration at message level
// (who owns the bus, how many beats remain) and queues the expected output
// per cycle; an independent monitor pops and compares on the falling edge.
module tb_coreriscv_axi4_beat_lock_arbiter;

    localparam int NBEATS = 4;
    localparam int ADDR_W = 26;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        in_valid;
    logic [3:0]        in_ready;
    logic [3:0]        in_hd;
    logic [1:0]        in_src   [4];
    logic [1:0]        in_dst   [4];
    logic [1:0]        in_ptype [4];
    logic [ADDR_W-1:0] in_addr  [4];
    logic              out_ready;
    logic              out_valid;
    logic [1:0]        out_src;
    logic [1:0]        out_dst;
    logic [ADDR_W-1:0] out_addr;
    logic [1:0]        out_ptype;
    logic              out_hd;
    logic [1:0]        chosen;

    typedef struct {
        bit              skip;
        bit              valid;
        int              chosen;
        bit [3:0]        ready;
        bit [1:0]        src;
        bit [1:0]        dst;
        bit [ADDR_W-1:0] addr;
        bit [1:0]        ptype;
        bit              hd;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    int   m_last  = 0;
    int   m_owner = -1;
    int   m_left  = 0;

    always #5 clk = ~clk;

    coreriscv_axi4_beat_lock_arbiter #(
        .NBEATS (NBEATS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk                             (clk),
        .reset                           (reset),
        .io_in_0_valid                   (in_valid[0]),
        .io_in_0_ready                   (in_ready[0]),
        .io_in_0_bits_header_src         (in_src[0]),
        .io_in_0_bits_header_dst         (in_dst[0]),
        .io_in_0_bits_payload_addr_block (in_addr[0]),
        .io_in_0_bits_payload_p_type     (in_ptype[0]),
        .io_in_0_bits_payload_has_data   (in_hd[0]),
        .io_in_1_valid                   (in_valid[1]),
        .io_in_1_ready                   (in_ready[1]),
        .io_in_1_bits_header_src         (in_src[1]),
        .io_in_1_bits_header_dst         (in_dst[1]),
        .io_in_1_bits_payload_addr_block (in_addr[1]),
        .io_in_1_bits_payload_p_type     (in_ptype[1]),
        .io_in_1_bits_payload_has_data   (in_hd[1]),
        .io_in_2_valid                   (in_valid[2]),
        .io_in_2_ready                   (in_ready[2]),
        .io_in_2_bits_header_src         (in_src[2]),
        .io_in_2_bits_header_dst         (in_dst[2]),
        .io_in_2_bits_payload_addr_block (in_addr[2]),
        .io_in_2_bits_payload_p_type     (in_ptype[2]),
        .io_in_2_bits_payload_has_data   (in_hd[2]),
        .io_in_3_valid                   (in_valid[3]),
        .io_in_3_ready                   (in_ready[3]),
        .io_in_3_bits_header_src         (in_src[3]),
        .io_in_3_bits_header_dst         (in_dst[3]),
        .io_in_3_bits_payload_addr_block (in_addr[3]),
        .io_in_3_bits_payload_p_type     (in_ptype[3]),
        .io_in_3_bits_payload_has_data   (in_hd[3]),
        .io_out_ready                    (out_ready),
        .io_out_valid                    (out_valid),
        .io_out_bits_header_src          (out_src),
        .io_out_bits_header_dst          (out_dst),
        .io_out_bits_payload_addr_block  (out_addr),
        .io_out_bits_payload_p_type      (out_ptype),
        .io_out_bits_payload_has_data    (out_hd),
        .io_chosen                       (chosen)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue what the
    // output must look like for that cycle; the model state then advances as
    // of the next rising edge.
    task automatic applyStimulus(input bit rst, input bit [3:0] vmask,
                                 input bit [3:0] hmask, input bit ordy);
        exp_t e;
        int   cand;
        int   ch;
        @(posedge clk);
        #1;
        reset     = rst;
        out_ready = ordy;
        in_valid  = vmask;
        in_hd     = hmask;
        for (int i = 0; i < 4; i++) begin
            in_src[i]   = 2'($urandom_range(0, 3));
            in_dst[i]   = 2'($urandom_range(0, 3));
            in_ptype[i] = 2'($urandom_range(0, 3));
            in_addr[i]  = ADDR_W'($urandom);
        end
        e = '{default: 0};
        if (rst) begin
            e.skip  = 1'b1;
            m_last  = 0;
            m_owner = -1;
            m_left  = 0;
        end else begin
            cand = -1;
            if (m_owner >= 0) begin
                ch = m_owner;
                if (vmask[ch]) cand = ch;
            end else begin
                ch = (m_last + 1) % 4;
                for (int k = 1; k <= 4; k++)
                    if (cand < 0 && vmask[(m_last + k) % 4]) cand = (m_last + k) % 4;
                if (cand >= 0) ch = cand;
            end
            e.valid  = (cand >= 0);
            e.chosen = ch;
            e.ready  = ordy ? 4'(1 << ch) : 4'b0;
            e.src    = in_src[ch];
            e.dst    = in_dst[ch];
            e.addr   = in_addr[ch];
            e.ptype  = in_ptype[ch];
            e.hd     = hmask[ch];
            if (cand >= 0 && ordy) begin
                m_last = ch;
                if (m_owner >= 0) begin
                    m_left--;
                    if (m_left == 0) m_owner = -1;
                end else if (hmask[ch] && NBEATS > 1) begin
                    m_owner = ch;
                    m_left  = NBEATS - 1;
                end
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: compare the DUT output with the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (!e.skip) begin
                    checkOutput("out_valid", 32'(out_valid), 32'(e.valid));
                    checkOutput("chosen",    32'(chosen),    32'(e.chosen));
                    checkOutput("in_ready",  32'(in_ready),  32'(e.ready));
                    if (e.valid) begin
                        checkOutput("src",      32'(out_src),   32'(e.src));
                        checkOutput("dst",      32'(out_dst),   32'(e.dst));
                        checkOutput("addr",     32'(out_addr),  32'(e.addr));
                        checkOutput("p_type",   32'(out_ptype), 32'(e.ptype));
                        checkOutput("has_data", 32'(out_hd),    32'(e.hd));
                    end
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic with occasional resets.
    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        in_valid  = '0;
        in_hd     = '0;
        for (int i = 0; i < 4; i++) begin
            in_src[i] = '0; in_dst[i] = '0; in_ptype[i] = '0; in_addr[i] = '0;
        end

        // Reset state: idle output, chosen points at requester 1.
        applyStimulus(1, 4'b0000, 4'b0000, 1);
        applyStimulus(1, 4'b0000, 4'b0000, 1);
        repeat (2) applyStimulus(0, 4'b0000, 4'b0000, 1);

        // All requesters valid with single beats: rotation 1,2,3,0,1.
        applyStimulus(1, 4'b0000, 4'b0000, 1);
        repeat (5) applyStimulus(0, 4'b1111, 4'b0000, 1);

        // Set lastGrant to 3, then in0 multi-beat against in2.
        applyStimulus(0, 4'b1000, 4'b0000, 1);
        repeat (6) applyStimulus(0, 4'b0101, 4'b0001, 1);

        // Lock on in1, in1 stalls for 3 cycles while in3 waits, then resumes.
        applyStimulus(1, 4'b0000, 4'b0000, 1);
        repeat (2) applyStimulus(0, 4'b0010, 4'b0010, 1);
        repeat (3) applyStimulus(0, 4'b1000, 4'b1000, 1);
        repeat (4) applyStimulus(0, 4'b1010, 4'b1010, 1);

        // Back-pressure for 5 cycles in the middle of a locked message.
        applyStimulus(1, 4'b0000, 4'b0000, 1);
        applyStimulus(0, 4'b0100, 4'b0100, 1);
        repeat (5) applyStimulus(0, 4'b1100, 4'b0100, 0);
        repeat (4) applyStimulus(0, 4'b1100, 4'b0100, 1);

        // Reset while in0 holds the lock after two beats; in1 wins next.
        applyStimulus(1, 4'b0000, 4'b0000, 1);
        applyStimulus(0, 4'b1000, 4'b0000, 1);
        repeat (2) applyStimulus(0, 4'b0001, 4'b0001, 1);
        applyStimulus(1, 4'b0001, 4'b0001, 1);
        repeat (3) applyStimulus(0, 4'b1011, 4'b0000, 1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 249) == 0),
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0));
        end

        repeat (2) @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coreriscv_axi4_beat_lock_arbiter.md
CORERISCV_AXI4_BEAT_LOCK_ARBITER -- requirements
Module: coreriscv_axi4_beat_lock_arbiter

Interface
REQ-001 SHALL have parameter NBEATS, default 4: beats per multi-beat message (legal range 1..16).
REQ-002 SHALL have parameter ADDR_W, default 26: width of the payload_addr_block field.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port io_in_<n>_valid, input, 1, n=0..3: requester n offers a beat.
REQ-006 SHALL have port io_in_<n>_ready, output, 1: beat from requester n accepted this cycle.
REQ-007 SHALL have ports io_in_<n>_bits_header_src and io_in_<n>_bits_header_dst, input, 2 each: routing header.
REQ-008 SHALL have port io_in_<n>_bits_payload_addr_block, input, ADDR_W: block address.
REQ-009 SHALL have port io_in_<n>_bits_payload_p_type, input, 2: message type.
REQ-010 SHALL have port io_in_<n>_bits_payload_has_data, input, 1: message is NBEATS beats long; otherwise 1 beat.
REQ-011 SHALL have port io_out_ready, input, 1: downstream accepts a beat.
REQ-012 SHALL have ports io_out_valid (output, 1), io_out_bits_* (output, same widths as inputs): the selected beat.
REQ-013 SHALL have port io_chosen, output, 2: index of the requester driving io_out.

Function
REQ-014 fire = io_out_valid & io_out_ready; at most one io_in_<n>_ready SHALL be high, and only for the chosen n, gated by io_out_ready.
REQ-015 When unlocked, priority SHALL be lastGrant+1, +2, +3 (mod 4), then lastGrant itself; the first valid requester in that order is chosen.
REQ-016 With no valid requester, io_chosen SHALL equal (lastGrant+1) mod 4 and io_out_valid SHALL be 0.
REQ-017 lastGrant SHALL load io_chosen on every fire.
REQ-018 On fire of a has_data beat while unlocked with NBEATS>1: locked<=1, lockIdx<=io_chosen, beatCnt<=1.
REQ-019 While locked, io_chosen SHALL equal lockIdx regardless of other valids; each fire increments beatCnt.
REQ-020 A fire with beatCnt==NBEATS-1 SHALL clear locked and beatCnt on the same edge; arbitration reopens next cycle.
REQ-021 If the locked requester deasserts valid mid-message, lock SHALL be held and io_out_valid SHALL be 0; no other requester is served.
REQ-022 Single-beat messages (has_data=0), or NBEATS=1, SHALL never set locked.
REQ-023 beatCnt SHALL be ceil(log2(NBEATS)) bits wide (minimum 1) and never exceed NBEATS-1.
REQ-024 Without the output register, io_out_* SHALL be combinational from the chosen input (0-cycle latency).

Reset
REQ-025 On reset: locked=0, beatCnt=0, lastGrant=0, skid buffer empty; io_out_valid=0 in the cycle following reset.
REQ-026 Reset asserted mid-message SHALL abandon the lock; the first cycle after reset arbitrates with priority order 1,2,3,0.

Configuration
REQ-027 Macro CORERISCV_AXI4_ARB_OUT_REG_EN SHALL, when defined, insert a 2-entry output skid buffer: io_out_* and io_chosen are registered, latency is 1 cycle, and throughput is 1 beat/cycle.
REQ-028 With CORERISCV_AXI4_ARB_OUT_REG_EN defined, input ready SHALL depend on buffer-not-full instead of io_out_ready, and lock and lastGrant SHALL update on the input-side handshake.
REQ-029 Without CORERISCV_AXI4_ARB_OUT_REG_EN, behaviour SHALL be exactly REQ-014 to REQ-024 and no output registers SHALL exist.

Structure
REQ-030 Shared package coreriscv_axi4_arb_pkg SHALL hold the constants NIN=4, IDX_W=2, and the beat/message field widths, plus the message bundle typedef.
REQ-031 The skid buffer SHALL be sub-module coreriscv_axi4_arb_out_slice, instantiated only under CORERISCV_AXI4_ARB_OUT_REG_EN.

Verification
REQ-032 After reset, all four valid, has_data=0, out_ready=1 -> grants 1,2,3,0,1 on consecutive cycles.
REQ-033 In0 has_data=1 and in2 valid, NBEATS=4, out_ready=1 -> in0 is granted 4 consecutive beats, then in2, with io_chosen held at 0 for cycles 0..3.
REQ-034 Locked on in1 after 2 beats, in1 valid drops for 3 cycles while in3 is valid -> io_out_valid=0 and io_in_3_ready=0 throughout; in1 resumes and finishes beats 3 and 4.
REQ-035 out_ready=0 for 5 cycles mid-lock -> beatCnt and lastGrant are unchanged, and the payload on io_out is stable.
REQ-036 Reset pulsed at beatCnt=2 while in0 is locked -> locked=0, and the next grant goes to in1 if in1 is valid.
REQ-037 With CORERISCV_AXI4_ARB_OUT_REG_EN and alternating out_ready -> no beat lost or duplicated, order is preserved, and output latency is 1 cycle.
